led_matrix_scanner: RTL and testbench

//  Parametrised, double-buffered row-scan driver for the VHDC LED matrix (default 5 col x 7 row).

---
 rtl/led_matrix_scanner_pkg.sv | 24 ++
 rtl/led_matrix_scanner_if.sv | 36 +++
 rtl/led_matrix_scanner_dbuf.sv | 57 +++++
 rtl/led_matrix_scanner.sv | 137 +++++++++++++
 tb/tb_led_matrix_scanner.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/led_matrix_scanner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_matrix_scanner_pkg                                                     |
// | Shared scan states, default geometry and helpers for the LED matrix driver.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package led_matrix_scanner_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    localparam int c_row_w     = 4;
    localparam int c_def_ncols = 5;
    localparam int c_def_nrows = 7;
    localparam int c_def_br_w  = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_matrix_scanner_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_matrix_scanner_if                                                      |
// | Upstream write/swap/brightness port plus matrix row and column drive pins. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface led_matrix_scanner_if
    import led_matrix_scanner_pkg::*;
#(
    parameter int NCOLS = c_def_ncols,
    parameter int NROWS = c_def_nrows,
    parameter int BR_W  = c_def_br_w
) ();

    logic               wr_en;
    logic [c_row_w-1:0] wr_row;
    logic [NCOLS-1:0]   wr_data;
    logic               swap_req;
    logic               swap_ack;
    logic [BR_W-1:0]    brightness;
    logic [NCOLS-1:0]   colOut;
    logic [NROWS-1:0]   rowOut;
    logic               frame_start;

    modport master (
        output wr_en, wr_row, wr_data, swap_req, brightness,
        input  swap_ack, colOut, rowOut, frame_start
    );

    modport slave (
        input  wr_en, wr_row, wr_data, swap_req, brightness,
        output swap_ack, colOut, rowOut, frame_start
    );

endinterface
`default_nettype wire

// File: rtl/led_matrix_scanner_dbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_matrix_scanner_dbuf                                                    |
// | Two-bank row register file: writes go to the back bank, reads from front.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module led_matrix_scanner_dbuf
    import led_matrix_scanner_pkg::*;
#(
    parameter int NCOLS = c_def_ncols,
    parameter int NROWS = c_def_nrows
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wr_en,
    input  logic [c_row_w-1:0] i_wr_row,
    input  logic [NCOLS-1:0]   i_wr_data,
    input  logic               i_swap,
    input  logic [c_row_w-1:0] i_rd_row,
    output logic [NCOLS-1:0]   o_rd_data
);

    logic             r_front;
    logic [NCOLS-1:0] r_mem [2][NROWS];

    // Write bank is chosen from the pre-swap front, so a write in the swap
    // cycle lands in the bank that becomes visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_front <= 1'b0;
            for (int r = 0; r < NROWS; r++) begin
                r_mem[0][r] <= '0;
                r_mem[1][r] <= '0;
            end
        end else begin
            if (i_swap) begin
                r_front <= ~r_front;
            end
            for (int r = 0; r < NROWS; r++) begin
                if (i_wr_en && (i_wr_row == c_row_w'(r))) begin
                    r_mem[~r_front][r] <= i_wr_data;
                end
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int r = 0; r < NROWS; r++) begin
            if (i_rd_row == c_row_w'(r)) begin
                o_rd_data = r_mem[r_front][r];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_matrix_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_matrix_scanner                                                         |
// | Double-buffered row-scan LED matrix driver with blanking and global PWM.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module led_matrix_scanner
    import led_matrix_scanner_pkg::*;
#(
    parameter int NCOLS       = c_def_ncols,
    parameter int NROWS       = c_def_nrows,
    parameter int DWELL       = 1024,
    parameter int BLANK       = 16,
    parameter int BR_W        = c_def_br_w,
    parameter int ROW_ACT_LOW = 1,
    parameter int COL_ACT_LOW = 0
) (
    input  logic                CLK,
    input  logic                reset,
    led_matrix_scanner_if.slave bus
);

    localparam int                 c_cnt_w      = $clog2(max2(DWELL, BLANK));
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK - 1);
    localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(DWELL - 1);
    localparam logic [c_row_w-1:0] c_row_last   = c_row_w'(NROWS - 1);
    localparam logic [NROWS-1:0]   c_row_inv    = {NROWS{ROW_ACT_LOW != 0}};
    localparam logic [NCOLS-1:0]   c_col_inv    = {NCOLS{COL_ACT_LOW != 0}};

    scan_state_t        r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [c_row_w-1:0] r_row, w_row_nxt;
    logic               r_pending, w_pending_nxt;
    logic               r_swap_done;
    logic               w_swap;
    logic               w_frame_start;
    logic [NROWS-1:0]   w_row_on;
    logic [NCOLS-1:0]   w_col_on;
    logic [NCOLS-1:0]   w_front_row;
    logic [NROWS-1:0]   r_row_out;
    logic [NCOLS-1:0]   r_col_out;
    logic               r_frame_start;
    logic               r_swap_ack;

    led_matrix_scanner_dbuf #(
        .NCOLS (NCOLS),
        .NROWS (NROWS)
    ) u_dbuf (
        .clk       (CLK),
        .rst       (reset),
        .i_wr_en   (bus.wr_en),
        .i_wr_row  (bus.wr_row),
        .i_wr_data (bus.wr_data),
        .i_swap    (w_swap),
        .i_rd_row  (r_row),
        .o_rd_data (w_front_row)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= ST_BLANK;
            r_cnt       <= '0;
            r_row       <= '0;
            r_pending   <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_row       <= w_row_nxt;
            r_pending   <= w_pending_nxt;
            r_swap_done <= w_swap;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_row_nxt   = r_row;
        w_swap      = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == c_blank_last) begin
                    w_state_nxt = ST_DRIVE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == c_dwell_last) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    if (r_row == c_row_last) begin
                        w_row_nxt = '0;
                        w_swap    = r_pending;
                    end else begin
                        w_row_nxt = r_row + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_BLANK;
        endcase

        // A request arriving in the swap cycle itself arms the following frame.
        w_pending_nxt = w_swap ? bus.swap_req : (r_pending | bus.swap_req);

        w_frame_start = (r_state == ST_BLANK) && (r_cnt == '0) && (r_row == '0);
        w_row_on      = '0;
        w_col_on      = '0;
        if (r_state == ST_DRIVE) begin
            w_row_on = NROWS'(1) << r_row;
            if (r_cnt[BR_W-1:0] < bus.brightness) begin
                w_col_on = w_front_row;
            end
        end
    end

    // swap_ack is delayed one stage so it lines up with the registered frame_start.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_row_out     <= c_row_inv;
            r_col_out     <= c_col_inv;
            r_frame_start <= 1'b0;
            r_swap_ack    <= 1'b0;
        end else begin
            r_row_out     <= w_row_on ^ c_row_inv;
            r_col_out     <= w_col_on ^ c_col_inv;
            r_frame_start <= w_frame_start;
            r_swap_ack    <= r_swap_done;
        end
    end

    assign bus.rowOut      = r_row_out;
    assign bus.colOut      = r_col_out;
    assign bus.frame_start = r_frame_start;
    assign bus.swap_ack    = r_swap_ack;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_led_matrix_scanner                                                      |
// | Directed bench: scan timing, double buffering, PWM, resets and polarity.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_led_matrix_scanner;

    localparam int c_frame = 252;
    localparam int c_slot  = 36;
    localparam int c_blank = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   swaps_due = 0;
    int   br = 15;
    logic [4:0] exp_front [7];
    logic [4:0] exp_back  [7];

    led_matrix_scanner_if #(.NCOLS(5), .NROWS(7), .BR_W(4)) bus ();
    led_matrix_scanner_if #(.NCOLS(5), .NROWS(7), .BR_W(4)) bus_p ();

    assign bus_p.wr_en      = bus.wr_en;
    assign bus_p.wr_row     = bus.wr_row;
    assign bus_p.wr_data    = bus.wr_data;
    assign bus_p.swap_req   = bus.swap_req;
    assign bus_p.brightness = bus.brightness;

    led_matrix_scanner #(
        .NCOLS(5), .NROWS(7), .DWELL(32), .BLANK(4), .BR_W(4),
        .ROW_ACT_LOW(1), .COL_ACT_LOW(0)
    ) dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus)
    );

    led_matrix_scanner #(
        .NCOLS(5), .NROWS(7), .DWELL(32), .BLANK(4), .BR_W(4),
        .ROW_ACT_LOW(0), .COL_ACT_LOW(1)
    ) dut_pol (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus_p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic wr(input int row, input logic [4:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_row  = 4'(row);
        bus.wr_data = d;
        if (row < 7) exp_back[row] = d;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.wr_en    = 1'b0;
        bus.swap_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_rowOut",      32'(bus.rowOut),        32'h7F);
            check("rst_colOut",      32'(bus.colOut),        32'h00);
            check("rst_frame_start", 32'(bus.frame_start),   32'h0);
            check("rst_swap_ack",    32'(bus.swap_ack),      32'h0);
            check("rst_pol_rowOut",  32'(bus_p.rowOut),      32'h00);
            check("rst_pol_colOut",  32'(bus_p.colOut),      32'h1F);
        end
        rst       = 1'b0;
        swaps_due = 0;
        for (int r = 0; r < 7; r++) begin
            exp_front[r] = '0;
            exp_back[r]  = '0;
        end
    endtask

    // Cycle c counts falling edges after reset release; the first one shows frame_start.
    task automatic step(input int c);
        int         p, k, q;
        logic [6:0] er, er_n;
        logic [4:0] ec, ec_n, t5;
        logic       ea;
        @(negedge clk);
        p  = c % c_frame;
        k  = p / c_slot;
        q  = p % c_slot;
        ea = 1'b0;
        if (c > 0 && p == 0 && swaps_due > 0) begin
            ea = 1'b1;
            swaps_due--;
            for (int r = 0; r < 7; r++) begin
                t5           = exp_front[r];
                exp_front[r] = exp_back[r];
                exp_back[r]  = t5;
            end
        end
        er = '0;
        ec = '0;
        if (q >= c_blank) begin
            er = 7'(1 << k);
            if (((q - c_blank) % 16) < br) ec = exp_front[k];
        end
        er_n = ~er;
        ec_n = ~ec;
        check($sformatf("rowOut@%0d", c),      32'(bus.rowOut),      32'(er_n));
        check($sformatf("colOut@%0d", c),      32'(bus.colOut),      32'(ec));
        check($sformatf("frame_start@%0d", c), 32'(bus.frame_start), 32'(p == 0));
        check($sformatf("swap_ack@%0d", c),    32'(bus.swap_ack),    32'(ea));
        check($sformatf("pol_rowOut@%0d", c),  32'(bus_p.rowOut),    32'(er));
        check($sformatf("pol_colOut@%0d", c),  32'(bus_p.colOut),    32'(ec_n));
    endtask

    initial begin
        bus.wr_en      = 1'b0;
        bus.wr_row     = '0;
        bus.wr_data    = '0;
        bus.swap_req   = 1'b0;
        bus.brightness = 4'(br);
        do_reset();

        for (int c = 0; c < 1420; c++) begin
            step(c);
            bus.wr_en    = 1'b0;
            bus.swap_req = 1'b0;
            case (c)
                10:   wr(2, 5'h15);
                20:   wr(9, 5'h1F);
                380:  begin bus.swap_req = 1'b1; swaps_due = 1; end
                450:  bus.swap_req = 1'b1;
                502:  begin wr(4, 5'h0A); bus.swap_req = 1'b1; swaps_due = 2; end
                600:  wr(0, 5'h1F);
                610:  wr(6, 5'h11);
                755:  br = 4;
                1007: br = 0;
                1259: br = 15;
                1270: begin bus.swap_req = 1'b1; swaps_due = 1; end
                default: ;
            endcase
            bus.brightness = 4'(br);
        end

        // Reset lands during row 4 DRIVE with a swap still pending.
        do_reset();
        for (int c = 0; c <= c_frame; c++) begin
            step(c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
